// File: rtl/uart_tx_fifo_drain.sv
// 8N1/8N2 UART transmitter that drains a show-ahead byte FIFO onto the TX pin.
// Back-to-back frames are sent with no idle gap while the FIFO stays non-empty.
module uart_tx_fifo_drain #(
   parameter int CLK_FREQ   = 27000000,
   parameter int BAUD       = 115200,
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_read_en,
   output logic                  tx,
   output logic                  busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;

   logic bit_done;
   logic last_stop;
   logic pop;

   always_comb begin
      bit_done  = (cnt_q == '0);
      last_stop = (state_q == STOP) && bit_done && (idx_q == LAST_STOP);
      pop       = !reset && enable && !fifo_empty && ((state_q == IDLE) || last_stop);

      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               cnt_d   = CNT_LOAD;
               idx_d   = '0;
               tx_d    = shift_q[0];
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_d = CNT_LOAD;
               if (idx_q == LAST_DATA) begin
                  state_d = STOP;
                  idx_d   = '0;
                  tx_d    = 1'b1;
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
                  idx_d   = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (idx_q == LAST_STOP) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  busy_d  = 1'b0;
               end else begin
                  idx_d = idx_q + 1'b1;
                  cnt_d = CNT_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A pop overrides the IDLE/STOP outcome so the next start bit follows immediately.
      if (pop) begin
         state_d = START;
         shift_d = fifo_data;
         cnt_d   = CNT_LOAD;
         idx_d   = '0;
         tx_d    = 1'b0;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign fifo_read_en = pop;
   assign tx           = tx_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three instances (10 clk/bit 1 stop, 10 clk/bit 2 stop,
// default 27 MHz/115200) fed from queue-based show-ahead FIFO models.
module tb_uart_tx_fifo_drain;

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic       enable = 1'b1;
   logic [7:0] data_a = 8'h00, data_b = 8'h00, data_c = 8'h00;
   logic       empty_a = 1'b1, empty_b = 1'b1, empty_c = 1'b1;
   logic       rd_a, rd_b, rd_c;
   logic       tx_a, tx_b, tx_c;
   logic       busy_a, busy_b, busy_c;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] qc[$];
   logic [7:0] exp_q[$];
   int         pops_a[$];
   int         pops_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo_drain #(.CLK_FREQ(1000), .BAUD(100), .DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .fifo_data(data_a), .fifo_empty(empty_a),
      .fifo_read_en(rd_a), .tx(tx_a), .busy(busy_a));

   uart_tx_fifo_drain #(.CLK_FREQ(1000), .BAUD(100), .DATA_WIDTH(8), .STOP_BITS(2)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .fifo_data(data_b), .fifo_empty(empty_b),
      .fifo_read_en(rd_b), .tx(tx_b), .busy(busy_b));

   uart_tx_fifo_drain #(.CLK_FREQ(27000000), .BAUD(115200), .DATA_WIDTH(8), .STOP_BITS(1)) dut_c (
      .clk(clk), .reset(reset), .enable(enable), .fifo_data(data_c), .fifo_empty(empty_c),
      .fifo_read_en(rd_c), .tx(tx_c), .busy(busy_c));

   function automatic void refresh();
      empty_a = (qa.size() == 0);
      data_a  = empty_a ? 8'h00 : qa[0];
      empty_b = (qb.size() == 0);
      data_b  = empty_b ? 8'h00 : qb[0];
      empty_c = (qc.size() == 0);
      data_c  = empty_c ? 8'h00 : qc[0];
   endfunction

   // Show-ahead FIFO models: the pop strobe is sampled at the edge, the head advances just after.
   always @(posedge clk) begin : fifo_model
      bit pa, pb, pc;
      pa = rd_a;
      pb = rd_b;
      pc = rd_c;
      if (pa) pops_a.push_back(cyc);
      if (pb) pops_b.push_back(cyc);
      #1;
      if (pa && qa.size() > 0) void'(qa.pop_front());
      if (pb && qb.size() > 0) void'(qb.pop_front());
      if (pc && qc.size() > 0) void'(qc.pop_front());
      refresh();
   end

   function automatic logic tx_of(input int inst);
      case (inst)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   // Decodes one frame by mid-bit sampling; ok=0 on timeout or bad start/stop level.
   task automatic rx_byte(input int inst, input int cpb, output logic [7:0] b, output bit ok,
                          output int t_start);
      int n;
      ok      = 1'b1;
      b       = 8'h00;
      t_start = -1;
      n       = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_of(inst) !== 1'b0 && n < 3000);
      if (tx_of(inst) !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      t_start = cyc;
      repeat (cpb / 2) @(negedge clk);
      if (tx_of(inst) !== 1'b0) ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
         repeat (cpb) @(negedge clk);
         b[k] = tx_of(inst);
      end
      repeat (cpb) @(negedge clk);
      if (tx_of(inst) !== 1'b1) ok = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || rd_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a: tx=%b busy=%b rd=%b required 1 0 0", tx_a, busy_a, rd_a);
      end
      n_checks++;
      if (tx_b !== 1'b1 || busy_b !== 1'b0 || rd_b !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_b: tx=%b busy=%b rd=%b required 1 0 0", tx_b, busy_b, rd_b);
      end
      n_checks++;
      if (tx_c !== 1'b1 || busy_c !== 1'b0 || rd_c !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_c: tx=%b busy=%b rd=%b required 1 0 0", tx_c, busy_c, rd_c);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_single_frame();
      logic [7:0] v = 8'hA5;
      logic       e;
      int         np;
      @(negedge clk);
      np = pops_a.size();
      qa.push_back(v);
      refresh();
      #1;
      n_checks++;
      if (rd_a !== 1'b1) begin
         n_fail++;
         $display("FAIL single_pop: rd=%b required 1", rd_a);
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         e = (i < 10) ? 1'b0 : (i < 90) ? v[(i-10)/10] : 1'b1;
         n_checks++;
         if (tx_a !== e || busy_a !== 1'b1 || rd_a !== 1'b0) begin
            n_fail++;
            $display("FAIL single_wave cyc%0d: tx=%b busy=%b rd=%b required %b 1 0",
                     i, tx_a, busy_a, rd_a, e);
         end
      end
      @(negedge clk);
      n_checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL single_end: tx=%b busy=%b required 1 0", tx_a, busy_a);
      end
      n_checks++;
      if (pops_a.size() - np !== 1) begin
         n_fail++;
         $display("FAIL single_pop_count: %0d required 1", pops_a.size() - np);
      end
      $display("test_single_frame byte=%h done", v);
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals[3] = '{8'h00, 8'hFF, 8'h3C};
      logic [7:0] b, e;
      bit         ok;
      int         ts[3];
      int         np;
      @(negedge clk);
      np = pops_a.size();
      for (int i = 0; i < 3; i++) begin
         qa.push_back(vals[i]);
         exp_q.push_back(vals[i]);
      end
      refresh();
      for (int i = 0; i < 3; i++) begin
         rx_byte(0, 10, b, ok, ts[i]);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         n_checks++;
         if (!ok || b !== e) begin
            n_fail++;
            $display("FAIL b2b_byte%0d: got=%h ok=%0d required %h", i, b, ok, e);
         end
         $display("b2b frame %0d rx=%h start_cyc=%0d", i, b, ts[i]);
      end
      n_checks++;
      if (ts[1] - ts[0] !== 100 || ts[2] - ts[1] !== 100) begin
         n_fail++;
         $display("FAIL b2b_start_gap: %0d %0d required 100 100", ts[1] - ts[0], ts[2] - ts[1]);
      end
      repeat (6) @(negedge clk);
      n_checks++;
      if (pops_a.size() - np !== 3) begin
         n_fail++;
         $display("FAIL b2b_pop_count: %0d required 3", pops_a.size() - np);
      end else begin
         n_checks++;
         if (pops_a[np+1] - pops_a[np] !== 100 || pops_a[np+2] - pops_a[np+1] !== 100) begin
            n_fail++;
            $display("FAIL b2b_pop_gap: %0d %0d required 100 100",
                     pops_a[np+1] - pops_a[np], pops_a[np+2] - pops_a[np+1]);
         end
      end
      n_checks++;
      if (empty_a !== 1'b1 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: empty=%b tx=%b busy=%b required 1 1 0", empty_a, tx_a, busy_a);
      end
   endtask

   task automatic test_enable();
      logic [7:0] b, e;
      bit         ok;
      int         ts;
      @(negedge clk);
      enable = 1'b0;
      qa.push_back(8'h96);
      exp_q.push_back(8'h96);
      refresh();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n_checks++;
         if (rd_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_low cyc%0d: rd=%b tx=%b busy=%b required 0 1 0",
                     i, rd_a, tx_a, busy_a);
         end
      end
      enable = 1'b1;
      #1;
      n_checks++;
      if (rd_a !== 1'b1) begin
         n_fail++;
         $display("FAIL enable_rise_pop: rd=%b required 1", rd_a);
      end
      @(negedge clk);
      n_checks++;
      if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL enable_start: tx=%b busy=%b required 0 1", tx_a, busy_a);
      end
      rx_byte(0, 10, b, ok, ts);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (!ok || b !== e) begin
         n_fail++;
         $display("FAIL enable_byte: got=%h ok=%0d required %h", b, ok, e);
      end
      $display("test_enable rx=%h", b);
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b, e;
      bit         ok;
      int         ts, np;
      @(negedge clk);
      np = pops_a.size();
      qa.push_back(8'h5A);
      refresh();
      repeat (45) @(negedge clk);
      reset = 1'b1;
      qa.push_back(8'hC3);
      exp_q.push_back(8'hC3);
      refresh();
      #1;
      n_checks++;
      if (rd_a !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_pop_during_frame: rd=%b required 0", rd_a);
      end
      @(negedge clk);
      n_checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || rd_a !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_abort: tx=%b busy=%b rd=%b required 1 0 0", tx_a, busy_a, rd_a);
      end
      reset = 1'b0;
      rx_byte(0, 10, b, ok, ts);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (!ok || b !== e) begin
         n_fail++;
         $display("FAIL midreset_next_byte: got=%h ok=%0d required %h", b, ok, e);
      end
      repeat (6) @(negedge clk);
      n_checks++;
      if (pops_a.size() - np !== 2 || empty_a !== 1'b1 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_pops: pops=%0d empty=%b busy=%b required 2 1 0",
                  pops_a.size() - np, empty_a, busy_a);
      end
      $display("test_reset_midframe rx=%h", b);
   endtask

   task automatic test_stop_bits2();
      logic [7:0] v = 8'h81;
      logic [7:0] b, e;
      logic       ex;
      bit         ok;
      int         ts, np;
      @(negedge clk);
      np = pops_b.size();
      qb.push_back(v);
      qb.push_back(8'h42);
      exp_q.push_back(8'h42);
      refresh();
      for (int i = 0; i < 110; i++) begin
         @(negedge clk);
         ex = (i < 10) ? 1'b0 : (i < 90) ? v[(i-10)/10] : 1'b1;
         n_checks++;
         if (tx_b !== ex || busy_b !== 1'b1 || rd_b !== (i == 109)) begin
            n_fail++;
            $display("FAIL stop2_wave cyc%0d: tx=%b busy=%b rd=%b required %b 1 %b",
                     i, tx_b, busy_b, rd_b, ex, (i == 109));
         end
      end
      rx_byte(1, 10, b, ok, ts);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (!ok || b !== e) begin
         n_fail++;
         $display("FAIL stop2_byte: got=%h ok=%0d required %h", b, ok, e);
      end
      repeat (16) @(negedge clk);
      n_checks++;
      if (pops_b.size() - np !== 2) begin
         n_fail++;
         $display("FAIL stop2_pop_count: %0d required 2", pops_b.size() - np);
      end else begin
         n_checks++;
         if (pops_b[np+1] - pops_b[np] !== 110) begin
            n_fail++;
            $display("FAIL stop2_frame_len: %0d required 110", pops_b[np+1] - pops_b[np]);
         end
      end
      n_checks++;
      if (tx_b !== 1'b1 || busy_b !== 1'b0) begin
         n_fail++;
         $display("FAIL stop2_end: tx=%b busy=%b required 1 0", tx_b, busy_b);
      end
      $display("test_stop_bits2 rx=%h", b);
   endtask

   task automatic test_defaults();
      logic [7:0] v = 8'h55;
      logic       e;
      @(negedge clk);
      qc.push_back(v);
      refresh();
      for (int i = 0; i < 2340; i++) begin
         @(negedge clk);
         e = (i < 234) ? 1'b0 : (i < 2106) ? v[(i-234)/234] : 1'b1;
         n_checks++;
         if (tx_c !== e || busy_c !== 1'b1) begin
            n_fail++;
            $display("FAIL default_wave cyc%0d: tx=%b busy=%b required %b 1", i, tx_c, busy_c, e);
         end
      end
      @(negedge clk);
      n_checks++;
      if (tx_c !== 1'b1 || busy_c !== 1'b0) begin
         n_fail++;
         $display("FAIL default_end: tx=%b busy=%b required 1 0", tx_c, busy_c);
      end
      $display("test_defaults byte=%h done", v);
   endtask

   initial begin
      refresh();
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_enable();
      test_reset_midframe();
      test_stop_bits2();
      test_defaults();
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
UART transmitter that sits directly downstream of the board's byte FIFO and drains it onto the serial TX pin. It pops bytes from the FIFO's show-ahead read interface and serialises them as 8N1 (or 8N2) frames, LSB first. Back-to-back bytes are sent with no idle gap while the FIFO is non-empty. It targets the Tang Nano 20K 27 MHz system clock.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer truncation, 234 at defaults); must be >= 2
DATA_WIDTH, 8, data bits per frame; must equal the FIFO DATA_WIDTH
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  when 0, no new frame starts; an in-flight frame always completes
fifo_data  input  DATA_WIDTH  FIFO head word (show-ahead: valid whenever fifo_empty=0)
fifo_empty  input  1  FIFO empty flag
fifo_read_en  output  1  one-cycle pop strobe to the FIFO read_en
tx  output  1  serial line, idle high
busy  output  1  1 while a frame is on the line (state != IDLE)

Behaviour:
- Reset (sync, active-high): state=IDLE, tx=1, busy=0, fifo_read_en=0, baud counter=0, bit index=0, shift reg=0. Reset held mid-frame aborts the frame: tx=1 from the next edge, and the partially sent byte is lost and not re-popped.
- States: IDLE, START, DATA, STOP.
- pop condition (combinational): fifo_read_en = !reset && enable && !fifo_empty && (state==IDLE || (state==STOP && last cycle of last stop bit)). It is never asserted when fifo_empty=1. At most one pop per frame.
- On a pop cycle: shift reg <= fifo_data; state <= START; tx <= 0; baud counter <= CLKS_PER_BIT-1. The start bit therefore appears on tx at the edge after the cycle in which fifo_read_en=1 (latency 1 cycle from IDLE with non-empty FIFO).
- Baud counter: counts down from CLKS_PER_BIT-1 to 0; every bit is held exactly CLKS_PER_BIT cycles. Width $clog2(CLKS_PER_BIT).
- START: at count 0 -> DATA, tx <= shift[0], bit index <= 0.
- DATA: at count 0 the shift reg shifts right and tx <= next bit; after bit DATA_WIDTH-1 -> STOP, tx <= 1.
- STOP: held for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle, if the pop condition holds, go directly to START (no idle cycles between frames). Otherwise go to IDLE.
- Frame length is exactly (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles, measured start-bit edge to the next possible start-bit edge.
- tx is a registered output with no glitches. busy is registered and is 1 from the first start-bit cycle through the last stop-bit cycle.
- enable falling mid-frame: the current frame finishes and no further pop occurs. enable rising with a non-empty FIFO in IDLE: pop in that same cycle.
- FIFO becoming non-empty mid-frame has no effect until the end of STOP.
- FIFO full or write activity is irrelevant; the block only ever reads.

Test Plan:
1. CLK_FREQ=1000, BAUD=100 (10 clk/bit), enable=1, FIFO holds 0xA5 -> fifo_read_en high exactly 1 cycle; tx low 10 cycles, then data bits 1,0,1,0,0,1,0,1 each 10 cycles, then high 10 cycles; busy high for 100 cycles, then 0.
2. Same params, FIFO holds 0x00,0xFF,0x3C -> three frames back-to-back with no idle gap; 3 pops spaced exactly 100 cycles apart; decoded bytes match in order; FIFO empty afterwards, tx=1, busy=0.
3. enable=0 with FIFO non-empty for 50 cycles -> no pop, tx=1, busy=0; enable=1 -> pop the same cycle and start bit on the next edge.
4. Assert reset for 1 cycle during data bit 3 of 0x5A -> tx=1 and busy=0 at the next edge, no pop during reset; a subsequent byte is sent intact after release.
5. STOP_BITS=2, FIFO holds 0x81 -> stop level held 20 cycles; frame is 110 cycles; next pop occurs on the last stop cycle.
6. Defaults (27 MHz/115200) with a single byte 0x55 -> each bit lasts 234 cycles; total frame is 2340 cycles.
